// File: rtl/sort4_pkg.sv
// Shared types for the 4-key sequential bitonic sorter: FSM states,
// comparator pass-select encoding and slot count.
package sort4_pkg;

  localparam int NSLOT = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Selects which slot pairing the shared comparators see this cycle.
  typedef enum logic [1:0] {
    PS_P1 = 2'd0,
    PS_P2 = 2'd1,
    PS_P3 = 2'd2
  } pass_e;

endpackage

// File: rtl/sort4_cx_pass.sv
// One bitonic stage for four keys: an operand mux feeds two shared
// compare-exchange units, and the results are routed back to their slots.
module sort4_cx_pass
  import sort4_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [NSLOT*W-1:0] keys_in,
  input  pass_e              pass,
  input  logic               dir,
  output logic [NSLOT*W-1:0] keys_out
);

  logic [W-1:0] k [NSLOT];

  for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
    assign k[i] = keys_in[W*i +: W];
  end

  logic [W-1:0] a0, b0, a1, b1;
  logic         up0, up1;

  // P1 builds a bitonic sequence (second pair runs opposite); P2/P3 merge.
  always_comb begin
    a0  = k[0];
    b0  = k[1];
    a1  = k[2];
    b1  = k[3];
    up0 = dir;
    up1 = ~dir;
    case (pass)
      PS_P2: begin
        a0  = k[0];
        b0  = k[2];
        a1  = k[1];
        b1  = k[3];
        up1 = dir;
      end
      PS_P3: begin
        up1 = dir;
      end
      default: ;
    endcase
  end

  // Strict compares: equal keys stay where they are.
  logic         swap0, swap1;
  logic [W-1:0] lo0, hi0, lo1, hi1;

  assign swap0 = up0 ? (a0 > b0) : (a0 < b0);
  assign swap1 = up1 ? (a1 > b1) : (a1 < b1);
  assign lo0   = swap0 ? b0 : a0;
  assign hi0   = swap0 ? a0 : b0;
  assign lo1   = swap1 ? b1 : a1;
  assign hi1   = swap1 ? a1 : b1;

  always_comb begin
    keys_out = {hi1, lo1, hi0, lo0};
    if (pass == PS_P2) begin
      keys_out = {hi1, hi0, lo1, lo0};
    end
  end

endmodule

// File: rtl/sort4_seq_ctrl.sv
// Sequential 4-key sorter: one block in, three compare-exchange passes over a
// single key register, sorted block held until the consumer takes it.
module sort4_seq_ctrl
  import sort4_pkg::*;
#(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               direction,
  input  logic [NSLOT*W-1:0] in_keys,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NSLOT*W-1:0] out_keys,
  output logic               busy,
  output state_e             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high. out_valid never depends on out_ready, and out_keys holds while
  // out_valid & ~out_ready. in_ready may depend on out_ready (DONE refill).

  state_e             state_q, state_d;
  logic [NSLOT*W-1:0] key_r;
  logic               dir_r;
  pass_e              pass_sel;
  logic [NSLOT*W-1:0] pass_keys;
  logic               accept;
  logic               computing;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign computing = (state_q == ST_P1) || (state_q == ST_P2) || (state_q == ST_P3);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_keys  = key_r;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    pass_sel = PS_P1;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_P1;
      end
      ST_P1: begin
        pass_sel = PS_P1;
        state_d  = ST_P2;
      end
      ST_P2: begin
        pass_sel = PS_P2;
        state_d  = ST_P3;
      end
      ST_P3: begin
        pass_sel = PS_P3;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = accept ? ST_P1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sort4_cx_pass #(.W(W)) u_cx_pass (
    .keys_in  (key_r),
    .pass     (pass_sel),
    .dir      (dir_r),
    .keys_out (pass_keys)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_r   <= '0;
      dir_r   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        key_r <= in_keys;
        dir_r <= direction;
      end else if (computing) begin
        key_r <= pass_keys;
      end
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Directed bench for sort4_seq_ctrl: latency, both orders, duplicates,
// back-pressure, back-to-back blocks and mid-sort reset.
module tb_sort4_seq_ctrl;
  import sort4_pkg::*;

  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             direction = 1'b1;
  logic [4*W-1:0]   in_keys = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [4*W-1:0]   out_keys;
  logic             busy;
  state_e           state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sort4_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .direction (direction),
    .in_keys   (in_keys),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_keys  (out_keys),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pk(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                        input logic [W-1:0] s2, input logic [W-1:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // Starts at a negedge with the DUT idle; scrambles inputs while in flight.
  task automatic run_block(input string tag, input logic [4*W-1:0] keys, input logic dir,
                           input logic [4*W-1:0] exp);
    in_valid  = 1'b1;
    in_keys   = keys;
    direction = dir;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_nordy"}, in_ready, 1'b0);
    in_valid  = 1'b0;
    in_keys   = ~keys;
    direction = ~dir;
    @(negedge clk);
    check_eq({tag, "_ov_p2"}, out_valid, 1'b0);
    direction = dir;
    @(negedge clk);
    check_eq({tag, "_ov_p3"}, out_valid, 1'b0);
    direction = ~dir;
    @(negedge clk);
    check_eq({tag, "_ov_done"}, out_valid, 1'b1);
    check_eq({tag, "_keys"}, out_keys, exp);
    check_eq({tag, "_rdy_done"}, in_ready, 1'b1);
    @(negedge clk);
    check_eq({tag, "_ov_after"}, out_valid, 1'b0);
    check_eq({tag, "_rdy_after"}, in_ready, 1'b1);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  logic [4*W-1:0] b2b_keys [3];
  logic           b2b_dir  [3];
  logic [4*W-1:0] held;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ov", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_keys", out_keys, '0);
    check_eq("rst_state", state_dbg, ST_IDLE);
    rst = 1'b1;
    #1 check_eq("rst_rdy", in_ready, 1'b1);

    // Accept on the first edge after release
    run_block("asc", pk(3, 1, 4, 2), 1'b1, pk(1, 2, 3, 4));
    run_block("desc", pk(3, 1, 4, 2), 1'b0, pk(4, 3, 2, 1));
    run_block("dup", pk(7, 7, 0, 16'hFFFF), 1'b1, pk(0, 7, 7, 16'hFFFF));
    run_block("dup_desc", pk(5, 16'hFFFF, 5, 16'h8000), 1'b0, pk(16'hFFFF, 16'h8000, 5, 5));

    // Back-pressure: a new block waits at the input throughout
    in_valid  = 1'b1;
    in_keys   = pk(40, 10, 30, 20);
    direction = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_keys   = pk(1, 2, 3, 4);
    direction = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("stall_ov", out_valid, 1'b1);
    check_eq("stall_keys0", out_keys, pk(10, 20, 30, 40));
    held = pk(10, 20, 30, 40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_hold_ov", out_valid, 1'b1);
      check_eq("stall_hold_keys", out_keys, held);
      check_eq("stall_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check_eq("stall_release_ov", out_valid, 1'b0);
    check_eq("stall_release_state", state_dbg, ST_IDLE);
    @(negedge clk);
    check_eq("stall_single_hs", out_valid, 1'b0);

    // Back-to-back: one block per four cycles
    b2b_keys[0] = pk(3, 1, 4, 2);                       b2b_dir[0] = 1'b1;
    b2b_keys[1] = pk(10, 20, 30, 40);                   b2b_dir[1] = 1'b0;
    b2b_keys[2] = pk(16'h1234, 1, 16'hFFFE, 16'h1234);  b2b_dir[2] = 1'b1;
    exp_q.push_back(pk(1, 2, 3, 4));
    exp_q.push_back(pk(40, 30, 20, 10));
    exp_q.push_back(pk(1, 16'h1234, 16'h1234, 16'hFFFE));
    in_valid  = 1'b1;
    in_keys   = b2b_keys[0];
    direction = b2b_dir[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 4 == 3) begin
        check_eq("b2b_ov", out_valid, 1'b1);
        if (exp_q.size() > 0) check_eq("b2b_keys", out_keys, exp_q.pop_front());
        else check_eq("b2b_queue", 64'(exp_q.size()), 64'd1);
        if (c < 11) begin
          in_keys   = b2b_keys[c/4 + 1];
          direction = b2b_dir[c/4 + 1];
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        check_eq("b2b_gap", out_valid, 1'b0);
      end
    end
    @(negedge clk);
    check_eq("b2b_end_state", state_dbg, ST_IDLE);
    check_eq("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Reset during P2 discards the block
    in_valid  = 1'b1;
    in_keys   = pk(5, 6, 7, 8);
    direction = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mrst_in_p2", state_dbg, ST_P2);
    rst = 1'b0;
    #1;
    check_eq("mrst_state", state_dbg, ST_IDLE);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_keys", out_keys, '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mrst_no_ov", out_valid, 1'b0);
    end
    run_block("post_rst", pk(9, 8, 7, 6), 1'b1, pk(6, 7, 8, 9));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
